// File: rtl/alu_seg_pkg.sv
// Shared constants for the segment calculator: operator codes, FSM states and segment patterns.
// Pure definitions; no state and no latency.
package alu_seg_pkg;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_e;

  // Active-low segments, bit6 = g ... bit0 = a.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/alu_seg_calc_seg_scan_mux.sv
// Self-timed digit scan for a common-anode display with leading-zero blanking and overflow dashes.
// Outputs follow the registered scan index combinationally; no backpressure.
module seg_scan_mux
  import alu_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_i,
  input  logic                  ovf_i,
  output logic [6:0]            wordout_o,
  output logic [DIGITS-1:0]     segout_o
);

  localparam int IW = $clog2(DIGITS);

  logic [SCAN_DIV-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tick;
  logic                lz;
  logic [3:0]          dig;

  assign tick       = &scan_cnt_q;
  assign scan_cnt_d = scan_cnt_q + SCAN_DIV'(1);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Index 0 is the most significant digit; lz stays set while every digit so far is zero.
  always_comb begin
    wordout_o = SEG_BLANK;
    segout_o  = '1;
    lz        = 1'b1;
    dig       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_i[4*(DIGITS-1-i) +: 4];
      lz  = lz && (dig == 4'd0);
      if (idx_q == IW'(i)) begin
        segout_o[i] = 1'b0;
        if (ovf_i) begin
          wordout_o = SEG_DASH;
        end else if (lz && (i != DIGITS - 1)) begin
          wordout_o = SEG_BLANK;
        end else begin
          wordout_o = seg_decode(dig);
        end
      end
    end
  end

endmodule

// File: rtl/alu_seg_calc.sv
// Add / sign-magnitude subtract / shift-add multiply calculator with double-dabble BCD display.
// done follows acceptance by (1 or W) + 2W cycles; start is ignored while busy, nothing is queued.
module alu_seg_calc
  import alu_seg_pkg::*;
#(
  parameter int W        = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [1:0]          operator,
  output logic                busy,
  output logic                done,
  output logic [2*W-1:0]      result,
  output logic                signout,
  output logic                ovf,
  output logic [6:0]          wordout,
  output logic [DIGITS-1:0]   segout
);

  localparam int CW = $clog2(2 * W) + 1;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [W-1:0]        b_q, b_d;
  logic [2*W-1:0]      mcand_q, mcand_d;
  logic [2*W-1:0]      mag_q, mag_d;
  logic                neg_q, neg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                dab_ovf_q, dab_ovf_d;
  logic [2*W-1:0]      result_q, result_d;
  logic                sign_q, sign_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] disp_bcd_q, disp_bcd_d;

  logic [W-1:0]        a_w;
  logic [4*DIGITS-1:0] adj;
  logic                carry;

  // Operand a lives in the low half of the multiplicand register; only multiply shifts it.
  assign a_w   = mcand_q[W-1:0];
  assign carry = adj[4*DIGITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (op_q != OP_MUL || cnt_q == CW'(W - 1)) state_d = CONV;
      CONV: if (cnt_q == CW'(2 * W - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == CONV);
    done = (state_q == DONE);
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = dabble_adj(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    op_d       = op_q;
    b_d        = b_q;
    mcand_d    = mcand_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    dab_ovf_d  = dab_ovf_q;
    result_d   = result_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    disp_bcd_d = disp_bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = operator;
          b_d     = b;
          mcand_d = {{W{1'b0}}, a};
          mag_d   = '0;
          neg_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        unique case (op_q)
          OP_ZERO: begin
            mag_d = '0;
            neg_d = 1'b0;
          end
          OP_ADD: begin
            mag_d = {{W{1'b0}}, a_w} + {{W{1'b0}}, b_q};
            neg_d = 1'b0;
          end
          OP_SUB: begin
            if (a_w >= b_q) begin
              mag_d = {{W{1'b0}}, a_w - b_q};
              neg_d = 1'b0;
            end else begin
              mag_d = {{W{1'b0}}, b_q - a_w};
              neg_d = 1'b1;
            end
          end
          default: begin
            if (b_q[0]) mag_d = mag_q + mcand_q;
            mcand_d = {mcand_q[2*W-2:0], 1'b0};
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
          end
        endcase
        if (state_d == CONV) begin
          cnt_d     = '0;
          bcd_d     = '0;
          dab_ovf_d = 1'b0;
        end
      end
      CONV: begin
        // Magnitude rotates rather than shifts, so after 2W steps it is intact for result.
        bcd_d     = {adj[4*DIGITS-2:0], mag_q[2*W-1]};
        dab_ovf_d = dab_ovf_q | carry;
        mag_d     = {mag_q[2*W-2:0], mag_q[2*W-1]};
        cnt_d     = cnt_q + CW'(1);
        if (state_d == DONE) begin
          result_d   = mag_d;
          disp_bcd_d = bcd_d;
          ovf_d      = dab_ovf_d;
          sign_d     = neg_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ZERO;
      b_q        <= '0;
      mcand_q    <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      dab_ovf_q  <= 1'b0;
      result_q   <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_bcd_q <= '0;
    end else begin
      op_q       <= op_d;
      b_q        <= b_d;
      mcand_q    <= mcand_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      dab_ovf_q  <= dab_ovf_d;
      result_q   <= result_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      disp_bcd_q <= disp_bcd_d;
    end
  end

  assign result  = result_q;
  assign signout = sign_q;
  assign ovf     = ovf_q;

  seg_scan_mux #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_i     (disp_bcd_q),
    .ovf_i     (ovf_q),
    .wordout_o (wordout),
    .segout_o  (segout)
  );

endmodule

// File: tb/tb_alu_seg_calc.sv
// Scoreboard bench for alu_seg_calc: expected results queued at start, checked on done and over the scan.
module tb_alu_seg_calc;

  localparam int TW = 8;
  localparam int TD = 4;
  localparam int TS = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [TW-1:0]   a;
  logic [TW-1:0]   b;
  logic [1:0]      operator;
  logic            busy;
  logic            done;
  logic [2*TW-1:0] result;
  logic            signout;
  logic            ovf;
  logic [6:0]      wordout;
  logic [TD-1:0]   segout;

  typedef struct {
    int                   res;
    bit                   neg;
    bit                   ovf;
    int                   lat;
    logic [TD-1:0][6:0]   words;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  alu_seg_calc #(.W(TW), .DIGITS(TD), .SCAN_DIV(TS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .operator (operator),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .signout  (signout),
    .ovf      (ovf),
    .wordout  (wordout),
    .segout   (segout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int av, input int bv, input int opv);
    exp_t e;
    int   d [TD];
    int   v;
    bit   lead;
    e.neg = 1'b0;
    case (opv)
      0: e.res = 0;
      1: e.res = av + bv;
      2: if (av >= bv) e.res = av - bv;
         else begin e.res = bv - av; e.neg = 1'b1; end
      default: e.res = av * bv;
    endcase
    e.ovf = (e.res > 9999);
    e.lat = ((opv == 3) ? TW : 1) + 2 * TW + 1;
    v = e.res;
    for (int i = TD - 1; i >= 0; i--) begin
      d[i] = v % 10;
      v    = v / 10;
    end
    lead = 1'b1;
    for (int i = 0; i < TD; i++) begin
      if (d[i] != 0) lead = 1'b0;
      if (e.ovf)                        e.words[i] = 7'b0111111;
      else if (lead && i != TD - 1)     e.words[i] = 7'b1111111;
      else                              e.words[i] = segtab[d[i]];
    end
    return e;
  endfunction

  task automatic check_scan(input exp_t e);
    logic [TD-1:0] want;
    int t;
    for (int i = 0; i < TD; i++) begin
      want = ~(TD'(1) << i);
      t = 0;
      while (segout !== want && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("seg_en%0d", i), segout, want);
      chk($sformatf("digit%0d", i), wordout, e.words[i]);
    end
    chk("scan_sign", signout, e.neg);
  endtask

  task automatic run_op(input int av, input int bv, input int opv, input bit disturb);
    exp_t e;
    int   edges;
    sb.push_back(model(av, bv, opv));
    @(negedge clk);
    a = TW'(av); b = TW'(bv); operator = 2'(opv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    chk("busy_after_accept", busy, 1);
    while (!done && edges < 80) begin
      if (disturb) begin
        start    = (edges == 3 || edges == 12);
        a        = 8'd99;
        b        = 8'd77;
        operator = 2'b11;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    e = sb.pop_front();
    chk("latency", edges, e.lat);
    chk("result", result, e.res);
    chk("signout", signout, e.neg);
    chk("ovf", ovf, e.ovf);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    check_scan(e);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; operator = 2'b00;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_signout", signout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_segout", segout, 4'b1110);
    chk("rst_wordout", wordout, 7'b1111111);
    @(negedge clk);
    rst_n = 1'b1;

    cnt = 0;
    while (segout === 4'b1110 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("tick_segout", segout, 4'b1101);
    chk("tick_wordout", wordout, 7'b1111111);

    run_op(200, 100, 1, 1'b0);
    run_op(5, 9, 2, 1'b0);
    run_op(7, 7, 2, 1'b0);
    run_op(123, 45, 0, 1'b0);
    run_op(255, 255, 3, 1'b0);
    run_op(10, 20, 1, 1'b1);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_extra_done", cnt, 0);
    chk("result_hold", result, 30);

    // Abort a multiply part-way through conversion.
    @(negedge clk);
    a = 8'd12; b = 8'd13; operator = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_signout", signout, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_segout", segout, 4'b1110);
    chk("abort_wordout", wordout, 7'b1111111);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    run_op(99, 101, 3, 1'b0);
    run_op(0, 255, 2, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_seg_calc.md
Name: alu_seg_calc

Overview:
- Parametrised successor to the 4-bit add/sub/mul calculator with a multiplexed 7-segment display.
- Latches two W-bit unsigned operands on a start/busy/done handshake and computes add, subtract (sign-magnitude) or multiply.
- Multiply is a sequential shift-add; binary-to-BCD conversion is a sequential double-dabble.
- Drives a DIGITS-wide common-anode display with a self-timed digit scan, leading-zero blanking and an overflow indication.

Parameters:
- W, 8, operand width in bits; result width is 2W.
- DIGITS, 4, number of displayed decimal digits (2..8).
- SCAN_DIV, 16, scan tick period is 2^SCAN_DIV clk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand 1, latched when start is accepted.
- b  in  W  operand 2, latched when start is accepted.
- operator  in  2  00 = zero result, 01 = a+b, 10 = |a-b| with sign, 11 = a*b; latched with operands.
- busy  out  1  high during CALC and CONV.
- done  out  1  one-cycle pulse; the display updates in the same cycle.
- result  out  2W  last completed binary magnitude.
- signout  out  1  high when the displayed result is negative (op 10 with a<b).
- ovf  out  1  result > 10^DIGITS-1.
- wordout  out  7  active-low segments, bit6 = g … bit0 = a.
- segout  out  DIGITS  active-low one-hot digit enable.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; busy, done, signout and ovf are 0; result is 0; displayed BCD is 0.
  - Scan index and scan counter are 0, so segout has bit0 low and all others high.
  - wordout is 7'b1111111, because digit 0 is a blanked leading zero (DIGITS>1).
- FSM states:
  - IDLE: start=1 latches a, b, operator and moves to CALC. start=0 stays in IDLE.
  - CALC: add, sub and zero take 1 cycle. Sub: if a>=b, mag = a-b and neg = 0; else mag = b-a and neg = 1. Mul takes exactly W cycles of shift-add over a 2W accumulator, LSB of the multiplier first. Then go to CONV.
  - CONV: double-dabble over the 2W-bit magnitude takes exactly 2W cycles, producing 4*DIGITS BCD bits plus an overflow detect. ovf_next = (mag > 10^DIGITS-1). Then go to DONE.
  - DONE: lasts 1 cycle. done=1 and the display registers load {bcd, neg, ovf_next}. result is loaded with mag. Then go to IDLE.
- Latency: start is accepted at edge k. done is high in the cycle after edge k+C+2W, where C=1 (ops 00/01/10) or C=W (op 11). For W=8: add/sub/zero gives done 18 cycles after acceptance; mul gives 25.
- start during CALC, CONV or DONE is ignored; there is no queueing. Operand changes after acceptance have no effect.
- Between computations the display and result hold the last DONE values.
- A reset mid-operation aborts the operation; no done pulse is produced; the display returns to its reset state.
- Scan:
  - A free-running SCAN_DIV-bit counter produces a tick on wrap.
  - Each tick advances the index modulo DIGITS, i.e. DIGITS-1 wraps to 0.
  - Index 0 is the most significant digit; segout bit i is low when index = i.
- Segments:
  - Digits 0–9 are decoded as 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Leading zeros above the most-significant nonzero digit are shown as 1111111.
  - The least significant digit (index DIGITS-1) is never blanked.
  - If ovf=1, every digit shows a dash (0111111), and signout still reflects the sign.
- signout = neg of the displayed result. It is 0 for ops 00, 01 and 11, and 0 for op 10 with a=b.

Decomposition:
- Package alu_seg_pkg:
  - Operator encodings OP_ZERO, OP_ADD, OP_SUB, OP_MUL.
  - FSM state enum (IDLE, CALC, CONV, DONE).
  - Segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH.
- One sub-module, seg_scan_mux. It contains the scan counter, index, leading-zero blanking, overflow dashes and digit decode. Inputs are the BCD vector and the ovf flag; outputs are wordout and segout.
- The FSM, multiplier and double-dabble stay in the top.

Test Plan:
- Reset then release, no start → busy=0, done=0, segout=1110, wordout=1111111 (W=8, DIGITS=4); after a scan tick, segout=1101.
- a=200, b=100, op=01, start → done exactly 18 cycles after acceptance; result=300; scanned digits blank, 3, 0, 0; signout=0.
- a=5, b=9, op=10 → result=4, signout=1, only the last digit is lit and shows 1111001 0011001… i.e. index 3 shows 0011001; a=7, b=7 → result=0, signout=0, last digit shows 1000000.
- a=255, b=255, op=11 → done at 25 cycles; result=65025; ovf=1; all four digits show 0111111.
- start pulsed again while busy, with a and b changed mid-operation → ignored; one done pulse; result from the originally latched operands.
- rst_n asserted during CONV of a multiply → outputs return to reset values immediately (asynchronous); no done pulse; a fresh start afterwards completes normally with correct latency.
